// File: rtl/opendap_dp_regs_multi_pkg.sv
// opendap_dp_pkg: DP address/bank encodings, CTRL/STAT and ABORT bit indices, AP tracking states.
package opendap_dp_pkg;
    localparam logic [1:0] A_DPIDR = 2'd0, A_CTRL_STAT = 2'd1, A_SELECT = 2'd2, A_RDBUFF = 2'd3;
    localparam logic [3:0] B_CTRL_STAT = 4'd0, B_DLCR = 4'd1, B_TARGETID = 4'd2, B_DLPIDR = 4'd3, B_EVENTSTAT = 4'd4;
    localparam int CS_ORUNDETECT = 0, CS_STICKYORUN = 1, CS_STICKYCMP = 4, CS_STICKYERR = 5, CS_READOK = 6,
                   CS_WDATAERR = 7, CS_CDBGPWRUPREQ = 28, CS_CSYSPWRUPREQ = 30;
    localparam int AB_DAPABORT = 0, AB_STKCMPCLR = 1, AB_STKERRCLR = 2, AB_WDERRCLR = 3, AB_ORUNERRCLR = 4;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ap_state_e;
endpackage

// File: rtl/opendap_dp_regs_multi_if.sv
// opendap_dp_regs_multi_if: hostacc bus between the serial comms unit (master) and the DP (slave).
interface opendap_dp_regs_multi_if;
    logic [1:0]  hostacc_addr;
    logic        hostacc_r_nw, hostacc_ap_ndp, hostacc_en;
    logic [31:0] hostacc_wdata, hostacc_rdata;
    logic        hostacc_fault, hostacc_wait, hostacc_protocol_err;
    modport master (output hostacc_addr, hostacc_r_nw, hostacc_ap_ndp, hostacc_en, hostacc_wdata,
                    input hostacc_rdata, hostacc_fault, hostacc_wait, hostacc_protocol_err);
    modport slave (input hostacc_addr, hostacc_r_nw, hostacc_ap_ndp, hostacc_en, hostacc_wdata,
                   output hostacc_rdata, hostacc_fault, hostacc_wait, hostacc_protocol_err);
endinterface

// File: rtl/opendap_dp_regs_multi_ap_mux.sv
// opendap_ap_mux: selects rdata/rdy/err of the active AP and decodes one-hot per-AP strobes.
module opendap_ap_mux #(
    parameter int NUM_APS = 4,
    parameter int AW = 2
) (
    input  logic [AW-1:0]          active_ap,
    input  logic [AW-1:0]          issue_ap,
    input  logic                   wen,
    input  logic                   ren,
    input  logic                   abort,
    input  logic [32*NUM_APS-1:0]  ap_rdata,
    input  logic [NUM_APS-1:0]     ap_rdy,
    input  logic [NUM_APS-1:0]     ap_err,
    output logic [31:0]            rdata,
    output logic                   rdy,
    output logic                   err,
    output logic [NUM_APS-1:0]     ap_wen,
    output logic [NUM_APS-1:0]     ap_ren,
    output logic [NUM_APS-1:0]     ap_abort
);
    logic [NUM_APS-1:0] issue_oh, active_oh;
    assign issue_oh = NUM_APS'(1) << issue_ap;
    assign active_oh = NUM_APS'(1) << active_ap;
    assign ap_wen = wen ? issue_oh : '0;
    assign ap_ren = ren ? issue_oh : '0;
    assign ap_abort = abort ? active_oh : '0;
    assign rdata = ap_rdata[32*int'(active_ap) +: 32];
    assign rdy = ap_rdy[active_ap];
    assign err = ap_err[active_ap];
endmodule

// File: rtl/opendap_dp_regs_multi.sv
// opendap_dp_regs_multi: SW-DP register file and AP router for NUM_APS access ports.
// Defining OPENDAP_AP_TIMEOUT_EN adds a watchdog that aborts an AP stuck BUSY for TIMEOUT_CYCLES.
module opendap_dp_regs_multi
    import opendap_dp_pkg::*;
#(
    parameter logic [31:0] DPIDR = 32'hdeadbeef,
    parameter logic [31:0] TARGETID = 32'hbaadf00d,
    parameter int NUM_APS = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  swclk,
    input  logic                  rst,
    opendap_dp_regs_multi_if.slave hif,
    input  logic                  set_wdataerr,
    input  logic                  set_stickyorun,
    input  logic                  clear_readok,
    output logic                  orundetect,
    output logic                  cdbgpwrupreq,
    input  logic                  cdbgpwrupack,
    output logic                  csyspwrupreq,
    input  logic                  csyspwrupack,
    input  logic [3:0]            instid,
    input  logic                  eventstat,
    output logic [5:0]            ap_addr,
    output logic [31:0]           ap_wdata,
    output logic [NUM_APS-1:0]    ap_wen,
    output logic [NUM_APS-1:0]    ap_ren,
    output logic [NUM_APS-1:0]    ap_abort,
    input  logic [32*NUM_APS-1:0] ap_rdata,
    input  logic [NUM_APS-1:0]    ap_rdy,
    input  logic [NUM_APS-1:0]    ap_err
);
    localparam int AW = NUM_APS > 1 ? $clog2(NUM_APS) : 1;
    ap_state_e state;
    logic [AW-1:0] active_ap;
    logic [31:0] select, resend_data, ctrl_stat, bank_rdata, mux_rdata, buf_rdata, wd;
    logic [7:0] apsel;
    logic [3:0] dpbank;
    logic [1:0] addr;
    logic sticky_orun, sticky_err, read_ok, wdata_err, resend_possible, rdbuff_zero;
    logic mux_rdy, mux_err, apsel_ok, ap_busy, exempt, acc, rd, wr, dp;
    logic ap_issue, ap_unimp, abort_wr, ctrl_wr, dlcr_wr, sel_wr, rdbuff_rd, resend_rd;
    logic set_readok, sticky_err_set, do_abort, timeout;
`ifdef OPENDAP_AP_TIMEOUT_EN
    localparam logic [31:0] DLCR_VAL = 32'h8000_0040;
    logic [31:0] tcnt;
    assign timeout = ap_busy && tcnt == 32'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge swclk) begin
        if (rst || !ap_busy || timeout || abort_wr) tcnt <= '0;
        else tcnt <= tcnt + 32'd1;
    end
`else
    localparam logic [31:0] DLCR_VAL = 32'h0000_0040;
    assign timeout = 1'b0;
`endif
    assign wd = hif.hostacc_wdata;
    assign addr = hif.hostacc_addr;
    assign dp = !hif.hostacc_ap_ndp;
    assign apsel = select[31:24];
    assign dpbank = select[3:0];
    assign apsel_ok = {1'b0, apsel} < 9'(NUM_APS);
    assign ap_busy = state == BUSY && !mux_rdy;
    // DPIDR, ABORT and bank-0 CTRL/STAT stay reachable while an AP is stalled
    assign exempt = dp && (hif.hostacc_r_nw ? (addr == A_DPIDR || (addr == A_CTRL_STAT && dpbank == B_CTRL_STAT))
                                            : addr == A_DPIDR);
    assign hif.hostacc_wait = ap_busy && !exempt;
    assign hif.hostacc_fault = hif.hostacc_ap_ndp && (sticky_err || sticky_orun || wdata_err);
    assign acc = hif.hostacc_en && !hif.hostacc_fault && !hif.hostacc_wait && !rst;
    assign rd = acc && hif.hostacc_r_nw;
    assign wr = acc && !hif.hostacc_r_nw;
    assign ap_issue = acc && !dp && apsel_ok;
    assign ap_unimp = acc && !dp && !apsel_ok;
    assign abort_wr = wr && dp && addr == A_DPIDR;
    assign ctrl_wr = wr && dp && addr == A_CTRL_STAT && dpbank == B_CTRL_STAT;
    assign dlcr_wr = wr && dp && addr == A_CTRL_STAT && dpbank == B_DLCR;
    assign sel_wr = wr && dp && addr == A_SELECT;
    assign rdbuff_rd = rd && dp && addr == A_RDBUFF;
    assign resend_rd = rd && dp && addr == A_SELECT;
    assign set_readok = rd && (!dp || addr == A_RDBUFF);
    assign sticky_err_set = ap_unimp || (state == BUSY && mux_rdy && mux_err) || timeout;
    assign do_abort = !rst && ((abort_wr && wd[AB_DAPABORT]) || timeout);
    assign ctrl_stat = {csyspwrupack, csyspwrupreq, cdbgpwrupack, cdbgpwrupreq, 20'h0,
                        wdata_err, read_ok, sticky_err, 1'b0, 2'b00, sticky_orun, orundetect};
    assign bank_rdata = dpbank == B_CTRL_STAT ? ctrl_stat :
                        dpbank == B_DLCR ? DLCR_VAL :
                        dpbank == B_TARGETID ? TARGETID :
                        dpbank == B_DLPIDR ? {instid, 24'h0, 4'h1} :
                        dpbank == B_EVENTSTAT ? {31'h0, eventstat} : '0;
    assign buf_rdata = rdbuff_zero ? '0 : mux_rdata;
    assign hif.hostacc_rdata = !dp ? (apsel_ok ? buf_rdata : '0) :
                               addr == A_DPIDR ? DPIDR :
                               addr == A_CTRL_STAT ? bank_rdata :
                               addr == A_SELECT ? (resend_possible ? resend_data : '0) : buf_rdata;
    assign hif.hostacc_protocol_err = (dlcr_wr && wd[9:8] != 2'b00) || (resend_rd && !resend_possible);
    assign ap_addr = {select[7:4], addr};
    assign ap_wdata = wd;
    opendap_ap_mux #(.NUM_APS(NUM_APS), .AW(AW)) u_ap_mux (
        .active_ap(active_ap),
        .issue_ap(apsel[AW-1:0]),
        .wen(ap_issue && !hif.hostacc_r_nw),
        .ren(ap_issue && hif.hostacc_r_nw),
        .abort(do_abort),
        .ap_rdata(ap_rdata),
        .ap_rdy(ap_rdy),
        .ap_err(ap_err),
        .rdata(mux_rdata),
        .rdy(mux_rdy),
        .err(mux_err),
        .ap_wen(ap_wen),
        .ap_ren(ap_ren),
        .ap_abort(ap_abort)
    );
    always_ff @(posedge swclk) begin
        if (rst) begin
            state <= IDLE;
            active_ap <= '0;
            select <= '0;
            resend_data <= '0;
            {orundetect, cdbgpwrupreq, csyspwrupreq} <= '0;
            {sticky_orun, sticky_err, read_ok, wdata_err, resend_possible, rdbuff_zero} <= '0;
        end else begin
            if (sel_wr) select <= wd;
            if (ctrl_wr) begin
                orundetect <= wd[CS_ORUNDETECT];
                cdbgpwrupreq <= wd[CS_CDBGPWRUPREQ];
                csyspwrupreq <= wd[CS_CSYSPWRUPREQ];
            end
            sticky_err <= sticky_err_set || (sticky_err && !(abort_wr && wd[AB_STKERRCLR]));
            sticky_orun <= set_stickyorun || (sticky_orun && !(abort_wr && wd[AB_ORUNERRCLR]));
            wdata_err <= set_wdataerr || (wdata_err && !(abort_wr && wd[AB_WDERRCLR]));
            read_ok <= (read_ok || set_readok) && !clear_readok;
            if (acc) resend_possible <= resend_rd ? resend_possible : set_readok;
            if (set_readok) resend_data <= hif.hostacc_rdata;
            if (ap_unimp && hif.hostacc_r_nw) rdbuff_zero <= 1'b1;
            else if (ap_issue) rdbuff_zero <= 1'b0;
            if (do_abort) state <= IDLE;
            else if (ap_issue) begin
                state <= BUSY;
                active_ap <= apsel[AW-1:0];
            end else if (state == BUSY && mux_rdy) state <= IDLE;
        end
    end
endmodule

// File: doc/opendap_dp_regs_multi.md
Name: opendap_dp_regs_multi

Overview:
- SW-DP register file and AP router for NUM_APS access ports. Generalises the single-AP DP: per-AP strobes, tracking of the in-flight AP, and a read buffer tied to the AP that produced it.
- Sits between opendap_sw_dp_serial_comms (hostacc bus) and up to NUM_APS AP instances.
- New over the single-AP DP: unimplemented-APSEL handling and an optional AP timeout watchdog.

Parameters:
- DPIDR, 32'hdeadbeef, value returned by DPIDR reads.
- TARGETID, 32'hbaadf00d, TARGETID register; bits [27:0] also feed TARGETSEL matching.
- NUM_APS, 4, number of AP channels, 1..256.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with OPENDAP_AP_TIMEOUT_EN; must be >= 2.

Ports:
- swclk in 1: sole clock.
- rst in 1: synchronous reset, active-high.
- hostacc_addr in 2: A[3:2] of the current packet.
- hostacc_r_nw in 1: 1 = read.
- hostacc_ap_ndp in 1: 1 = AP access.
- hostacc_wdata in 32: write data.
- hostacc_en in 1: access strobe, one cycle.
- hostacc_rdata out 32: combinational read data.
- hostacc_fault out 1: combinational FAULT response.
- hostacc_wait out 1: combinational WAIT response.
- hostacc_protocol_err out 1: bad TURNROUND write, or RESEND not possible.
- set_wdataerr, set_stickyorun, clear_readok in 1 each: from the serial unit.
- orundetect out 1: CTRL/STAT.ORUNDETECT.
- cdbgpwrupreq out 1, cdbgpwrupack in 1, csyspwrupreq out 1, csyspwrupack in 1: power handshakes.
- instid in 4, eventstat in 1: DLPIDR.TINSTANCE and EVENTSTAT inputs.
- ap_addr out 6: {APBANKSEL, A[3:2]}.
- ap_wdata out 32: write data to the APs.
- ap_wen, ap_ren, ap_abort out NUM_APS each: one-hot per-AP strobes.
- ap_rdata in 32*NUM_APS: AP n occupies bits [32n+31:32n].
- ap_rdy, ap_err in NUM_APS each: per-AP ready and error.

Behaviour:
- Reset values:
  - SELECT, CTRL/STAT bits, resend_possible: 0.
  - FSM: IDLE; active_ap: 0; timeout counter: 0.
  - All ap_* strobes and power requests: 0.
- DP registers:
  - DPIDR, ABORT, CTRL/STAT, DLCR, TARGETID, DLPIDR, EVENTSTAT, SELECT, RESEND and RDBUFF are decoded exactly as in the single-AP DP.
  - Register writes take effect at the swclk edge on which hostacc_en is high.
- Access qualification:
  - write = en && !fault && !r_nw; read = en && !fault && r_nw.
  - fault = ap_ndp && (STICKYERR | STICKYORUN | WDATAERR).
- AP tracking FSM:
  - IDLE to BUSY on an AP read or write with APSEL < NUM_APS. On that cycle, assert ap_ren[APSEL] or ap_wen[APSEL] and latch active_ap = APSEL.
  - BUSY to IDLE on the first cycle ap_rdy[active_ap] = 1. If ap_err[active_ap] is also 1 that cycle, set STICKYERR.
- WAIT:
  - ap_busy = (state == BUSY) && !ap_rdy[active_ap].
  - hostacc_wait = ap_busy, except for DPIDR read, ABORT write, and CTRL/STAT read with DPBANKSEL = 0.
- Unimplemented APSEL (>= NUM_APS):
  - Access completes with OK; no strobe is issued; FSM stays IDLE.
  - Read data is 0. STICKYERR is set on the next edge.
- Read data:
  - AP reads and RDBUFF return ap_rdata[active_ap], not the current APSEL. A SELECT write between an AP read and an RDBUFF read does not change the data.
  - After an unimplemented-APSEL read, RDBUFF returns 0 until the next valid AP access.
- ABORT:
  - DAPABORT = 1 pulses ap_abort[active_ap] for one cycle, in any FSM state.
  - FSM goes to IDLE on the next edge.
- Simultaneous events:
  - A sticky set and a clear via ABORT on the same edge: set wins.
  - READOK = (READOK | set_readok) & !clear_readok.
- RESEND:
  - Allowed only if the previous accepted access was an AP read, RDBUFF read or RESEND. Otherwise assert hostacc_protocol_err.
- Reset in BUSY:
  - FSM returns to IDLE and no abort pulse is issued. The APs share rst.

Optional Feature:
- Macro: OPENDAP_AP_TIMEOUT_EN.
- Defined:
  - A counter increments every cycle in BUSY while ap_rdy[active_ap] = 0, and clears on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1, assert ap_abort[active_ap] for one cycle and set STICKYERR. FSM goes to IDLE on the next edge.
  - DLCR bit 31 reads 1 (watchdog present).
- Undefined: no counter; DLCR reads 32'h0000_0040; BUSY persists until rdy or ABORT.

Decomposition:
- Package opendap_dp_pkg holds:
  - DP address/bank encodings (DPIDR=0, CTRL_STAT=1, SELECT=2, RDBUFF=3; banks 0-4).
  - CTRL/STAT and ABORT bit indices.
  - FSM state constants (IDLE=0, BUSY=1).
- One sub-module, opendap_ap_mux: NUM_APS-to-1 mux of rdata/rdy/err on active_ap, plus one-hot decode of strobes.

Test Plan:
- NUM_APS=4, SELECT=0x0200_0000, AP read with ap_rdy[2] low for 3 cycles:
  - ap_ren = 4'b0100 for 1 cycle.
  - WAIT on the next 3 accesses; DPIDR read still OK.
  - RDBUFF returns ap_rdata[2].
- AP read with APSEL=2, then SELECT write with APSEL=1, then RDBUFF: data equals ap_rdata[2] = 0x1234_5678.
- APSEL=7 with NUM_APS=4, AP write:
  - OK response; no ap_wen bit set.
  - STICKYERR=1; the next AP access returns FAULT.
- ABORT write 0x1F while BUSY on AP 3:
  - ap_abort = 4'b1000 for 1 cycle.
  - FSM IDLE; STICKYERR, WDATAERR and STICKYORUN all cleared.
- set_stickyorun and ABORT.ORUNERRCLR on the same cycle: STICKYORUN reads 1.
- With OPENDAP_AP_TIMEOUT_EN and TIMEOUT_CYCLES=8, ap_rdy held low:
  - ap_abort pulse exactly 8 cycles after issue.
  - STICKYERR=1; WAIT deasserts the following cycle.
